// File: rtl/instr_loader.sv
// instr_loader
//   Upstream feeder for the instruction register. Instructions arrive on a
//   valid/ready stream and are buffered in a small FIFO. A start pulse
//   launches a burst that writes `count` instructions into consecutive
//   register slots beginning at `base_addr`, wrapping modulo 2**ADDR_W.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   in_valid/ready   instruction stream handshake (ready = FIFO not full)
//   in_opcode        4-bit opcode
//   in_operand_a/b   32-bit signed operands
//   start            one-cycle pulse, honoured only in IDLE
//   base_addr        first slot of the burst (sampled on start)
//   count            number of writes, 0..2**ADDR_W (sampled on start)
//   busy             high while the burst is in LOAD
//   done             one-cycle pulse when the burst completes
//   load_en          register write strobe
//   write_pointer    slot addressed by load_en
//   opcode/operand_a/operand_b  registered fields presented with load_en
module instr_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          in_opcode,
    input  logic signed [31:0]  in_operand_a,
    input  logic signed [31:0]  in_operand_b,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     count,
    output logic                busy,
    output logic                done,
    output logic                load_en,
    output logic [ADDR_W-1:0]   write_pointer,
    output logic [3:0]          opcode,
    output logic signed [31:0]  operand_a,
    output logic signed [31:0]  operand_b
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  OCC_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] REM_ONE  = (ADDR_W+1)'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [31:0] operand_a;
        logic [31:0] operand_b;
    } instr_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    instr_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;
    instr_t           head;
    logic             push;
    logic             pop;

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;

    // Ready looks only at pre-pop occupancy, so a full FIFO refuses a push
    // even in a cycle where it is also being popped.
    assign in_ready = (occ != OCC_FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_LOAD) && (occ != '0) && (remaining != '0);
    assign head     = mem[rd_ptr];

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{opcode:    in_opcode,
                             operand_a: in_operand_a,
                             operand_b: in_operand_b};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr       <= base_addr;
                        remaining <= count;
                        state     <= (count == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    // An empty FIFO simply stalls here.
                    if (pop) begin
                        ptr       <= ptr + 1'b1;      // wraps modulo 2**ADDR_W
                        remaining <= remaining - 1'b1;
                        if (remaining == REM_ONE) state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_LOAD);
    assign done = (state == S_DONE);

    // ------------------------------------------------------------------
    // Registered register-write port. Fields and pointer only change on a
    // pop, so they hold the last written instruction while load_en is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_en       <= 1'b0;
            write_pointer <= '0;
            opcode        <= '0;
            operand_a     <= '0;
            operand_b     <= '0;
        end else begin
            load_en <= pop;
            if (pop) begin
                write_pointer <= ptr;
                opcode        <= head.opcode;
                operand_a     <= head.operand_a;
                operand_b     <= head.operand_b;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MULT = 4'h3;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         in_opcode;
    logic signed [31:0] in_operand_a;
    logic signed [31:0] in_operand_b;
    logic               start;
    logic [4:0]         base_addr;
    logic [5:0]         count;
    logic               busy;
    logic               done;
    logic               load_en;
    logic [4:0]         write_pointer;
    logic [3:0]         opcode;
    logic signed [31:0] operand_a;
    logic signed [31:0] operand_b;

    int checks   = 0;
    int failures = 0;

    instr_loader #(.FIFO_DEPTH(4), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_operand_a(in_operand_a), .in_operand_b(in_operand_b),
        .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .load_en(load_en),
        .write_pointer(write_pointer), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input int a, input int b);
        in_valid = 1'b1; in_opcode = op; in_operand_a = a; in_operand_b = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [4:0] base, input logic [5:0] cnt);
        start = 1'b1; base_addr = base; count = cnt;
        tick();
        start = 1'b0;
    endtask

    // Downstream register's view of the written instruction.
    function automatic int exec(input logic [3:0] op, input int a, input int b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MULT: return a * b;
            default: return 0;
        endcase
    endfunction

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_operand_a = 0; in_operand_b = 0;
        start = 1'b0; base_addr = '0; count = '0;
        repeat (2) tick();
        checks++;
        if ({busy, done, load_en, write_pointer, opcode, operand_a, operand_b} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b load_en=%b wp=%0d op=%h a=%0d b=%0d exp all 0",
                     busy, done, load_en, write_pointer, opcode, operand_a, operand_b);
        end
        #2 reset = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [3:0] e_op [3];
        int e_a [3];
        int e_b [3];
        int e_r [3];
        e_op = '{OP_ADD, OP_SUB, OP_MULT};
        e_a  = '{5, 10, -2};
        e_b  = '{3, 4, 7};
        e_r  = '{8, 6, -14};
        for (int i = 0; i < 3; i++) push(e_op[i], e_a[i], e_b[i]);
        issue(5'd0, 6'd3);
        checks++;
        if (busy !== 1'b1 || load_en !== 1'b0) begin
            failures++; $display("FAIL basic_enter_load got busy=%b load_en=%b exp busy=1 load_en=0", busy, load_en);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (load_en !== 1'b1 || write_pointer !== 5'(i) || opcode !== e_op[i] ||
                operand_a !== e_a[i] || operand_b !== e_b[i]) begin
                failures++;
                $display("FAIL basic_write%0d got en=%b wp=%0d op=%h a=%0d b=%0d exp en=1 wp=%0d op=%h a=%0d b=%0d",
                         i, load_en, write_pointer, opcode, operand_a, operand_b, i, e_op[i], e_a[i], e_b[i]);
            end
            checks++;
            if (exec(opcode, operand_a, operand_b) !== e_r[i]) begin
                failures++;
                $display("FAIL basic_result%0d got=%0d exp=%0d", i, exec(opcode, operand_a, operand_b), e_r[i]);
            end
            checks++;
            if (done !== (i == 2)) begin
                failures++; $display("FAIL basic_done%0d got=%b exp=%b", i, done, (i == 2));
            end
        end
        tick();
        checks++;
        if (load_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || write_pointer !== 5'd2 || opcode !== OP_MULT) begin
            failures++;
            $display("FAIL basic_hold got en=%b done=%b busy=%b wp=%0d op=%h exp en=0 done=0 busy=0 wp=2 op=%h",
                     load_en, done, busy, write_pointer, opcode, OP_MULT);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) push(4'h4, 100 + i, i);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_full got in_ready=%b exp=0", in_ready);
        end
        // Fifth item held by upstream.
        in_valid = 1'b1; in_opcode = 4'h5; in_operand_a = 104; in_operand_b = 4;
        repeat (2) tick();
        issue(5'd8, 6'd5);
        checks++;
        if (in_ready !== 1'b0 || load_en !== 1'b0) begin
            failures++; $display("FAIL bp_held got in_ready=%b load_en=%b exp in_ready=0 load_en=0", in_ready, load_en);
        end
        tick();                 // first pop; push still refused this edge
        checks++;
        if (in_ready !== 1'b1 || load_en !== 1'b1 || write_pointer !== 5'd8 || operand_a !== 100) begin
            failures++;
            $display("FAIL bp_first_pop got in_ready=%b en=%b wp=%0d a=%0d exp in_ready=1 en=1 wp=8 a=100",
                     in_ready, load_en, write_pointer, operand_a);
        end
        tick();                 // fifth item accepted here
        in_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (load_en !== 1'b1 || write_pointer !== 5'(8 + i) || operand_a !== 100 + i ||
                opcode !== ((i == 4) ? 4'h5 : 4'h4)) begin
                failures++;
                $display("FAIL bp_write%0d got en=%b wp=%0d op=%h a=%0d exp en=1 wp=%0d a=%0d",
                         i, load_en, write_pointer, opcode, operand_a, 8 + i, 100 + i);
            end
            if (i < 4) tick();
        end
        checks++;
        if (done !== 1'b1) begin
            failures++; $display("FAIL bp_done got=%b exp=1", done);
        end
        tick();
        checks++;
        if (load_en !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_drained got en=%b done=%b in_ready=%b exp 0 0 1", load_en, done, in_ready);
        end
    endtask

    task automatic test_wrap_trickle();
        logic [4:0] e_wp [4];
        e_wp = '{5'd30, 5'd31, 5'd0, 5'd1};
        issue(5'd30, 6'd4);
        for (int i = 0; i < 4; i++) begin
            push(4'h6, 200 + i, -i);
            checks++;
            if (load_en !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL wrap_gap_a%0d got en=%b busy=%b exp en=0 busy=1", i, load_en, busy);
            end
            tick();
            checks++;
            if (load_en !== 1'b1 || write_pointer !== e_wp[i] || operand_a !== 200 + i || operand_b !== -i ||
                busy !== (i != 3) || done !== (i == 3)) begin
                failures++;
                $display("FAIL wrap_write%0d got en=%b wp=%0d a=%0d b=%0d busy=%b done=%b exp en=1 wp=%0d a=%0d",
                         i, load_en, write_pointer, operand_a, operand_b, busy, done, e_wp[i], 200 + i);
            end
            tick();
            checks++;
            if (load_en !== 1'b0 || done !== 1'b0 || busy !== (i != 3)) begin
                failures++; $display("FAIL wrap_gap_b%0d got en=%b done=%b busy=%b", i, load_en, done, busy);
            end
        end
    endtask

    task automatic test_count_zero();
        push(OP_ADD, 7, 1);
        push(OP_SUB, 9, 2);
        issue(5'd5, 6'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || load_en !== 1'b0) begin
            failures++; $display("FAIL zero_done got done=%b busy=%b en=%b exp 1 0 0", done, busy, load_en);
        end
        tick();
        checks++;
        if (done !== 1'b0 || load_en !== 1'b0) begin
            failures++; $display("FAIL zero_after got done=%b en=%b exp 0 0", done, load_en);
        end
        // Both queued words must still be there for the next burst.
        issue(5'd3, 6'd2);
        tick();
        checks++;
        if (load_en !== 1'b1 || write_pointer !== 5'd3 || opcode !== OP_ADD || operand_a !== 7) begin
            failures++; $display("FAIL zero_kept0 got en=%b wp=%0d op=%h a=%0d exp 1 3 %h 7", load_en, write_pointer, opcode, operand_a, OP_ADD);
        end
        tick();
        checks++;
        if (load_en !== 1'b1 || write_pointer !== 5'd4 || opcode !== OP_SUB || operand_a !== 9 || done !== 1'b1) begin
            failures++; $display("FAIL zero_kept1 got en=%b wp=%0d op=%h a=%0d done=%b", load_en, write_pointer, opcode, operand_a, done);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 3; i++) push(4'h7, 300 + i, 0);
        issue(5'd10, 6'd3);
        issue(5'd20, 6'd1);     // arrives while in LOAD
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (load_en !== 1'b1 || write_pointer !== 5'(10 + i) || operand_a !== 300 + i || done !== (i == 2)) begin
                failures++;
                $display("FAIL ign_write%0d got en=%b wp=%0d a=%0d done=%b exp en=1 wp=%0d a=%0d",
                         i, load_en, write_pointer, operand_a, done, 10 + i, 300 + i);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || load_en !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL ign_idle got busy=%b en=%b done=%b exp 0 0 0", busy, load_en, done);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 4; i++) push(4'h8, 400 + i, 0);
        issue(5'd4, 6'd5);
        tick();
        tick();
        checks++;
        if (load_en !== 1'b1 || write_pointer !== 5'd5) begin
            failures++; $display("FAIL mid_second_write got en=%b wp=%0d exp en=1 wp=5", load_en, write_pointer);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (load_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1 || write_pointer !== 5'd0) begin
            failures++;
            $display("FAIL mid_async got en=%b busy=%b done=%b in_ready=%b wp=%0d exp 0 0 0 1 0",
                     load_en, busy, done, in_ready, write_pointer);
        end
        tick();
        #2 reset = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || load_en !== 1'b0) begin
            failures++; $display("FAIL mid_no_done got done=%b en=%b exp 0 0", done, load_en);
        end
        // Flushed FIFO: the only word written next must be the new one.
        push(OP_ADD, 55, 66);
        issue(5'd12, 6'd1);
        checks++;
        if (load_en !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL mid_restart got en=%b busy=%b exp 0 1", load_en, busy);
        end
        tick();
        checks++;
        if (load_en !== 1'b1 || write_pointer !== 5'd12 || operand_a !== 55 || operand_b !== 66 || done !== 1'b1) begin
            failures++;
            $display("FAIL mid_new_burst got en=%b wp=%0d a=%0d b=%0d done=%b exp 1 12 55 66 1",
                     load_en, write_pointer, operand_a, operand_b, done);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap_trickle();
        test_count_zero();
        test_start_ignored();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
